wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 187 ++++++++++++++++++
 tb/tb_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake into the integer
// register file. Loads wait for the data-memory response, are aligned and
// extended, then commit the cycle after the response arrives. A load whose
// response never arrives is abandoned after TIMEOUT_CYCLES and retires without
// writing.
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic        in_rd_wen,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_result,
    input  logic        in_is_load,
    input  logic [1:0]  in_ld_size,
    input  logic        in_ld_unsigned,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        wr_en,
    output logic [4:0]  index_rd,
    output logic [63:0] data_rd,
    output logic        update,
    output logic [63:0] commit_pc,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [63:0] fwd_data,
    output logic        ld_pending,
    output logic [4:0]  ld_pending_rd,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Compared against counter+1 so the sum never wraps for TIMEOUT_CYCLES=65535.
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_pc;
    logic [4:0]  r_rd;
    logic        r_rd_wen;
    logic [63:0] r_result;
    logic        r_is_load;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_cnt;
    logic        r_err;

    logic        w_accept;
    logic        w_timeout;
    logic        w_commit;
    logic [7:0]  w_bytes [8];
    logic [15:0] w_halves [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;
    logic [63:0] w_ld_value;

    assign in_ready = !rst && (r_state == IDLE || r_state == COMMIT);
    assign w_accept = in_valid && in_ready;
    // mem_rvalid has priority over an expiring counter.
    assign w_timeout = (r_state == WAIT) && !mem_rvalid &&
                       (({1'b0, r_cnt} + 17'd1) == TIMEOUT_LIMIT);
    assign w_commit = !rst && (r_state == COMMIT);

    // Split the returned doubleword into byte and halfword lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_lane
            assign w_bytes[gi] = mem_rdata[gi*8 +: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_half_lane
            assign w_halves[gi] = mem_rdata[gi*16 +: 16];
        end
    endgenerate

    assign w_byte = w_bytes[r_result[2:0]];
    assign w_half = w_halves[r_result[2:1]];
    assign w_word = r_result[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    // Select the addressed field and sign- or zero-extend it; D ignores unsigned.
    always_comb begin
        w_ld_value = mem_rdata;
        case (r_size)
            2'd0: w_ld_value = r_unsigned ? {56'd0, w_byte} : {{56{w_byte[7]}}, w_byte};
            2'd1: w_ld_value = r_unsigned ? {48'd0, w_half} : {{48{w_half[15]}}, w_half};
            2'd2: w_ld_value = r_unsigned ? {32'd0, w_word} : {{32{w_word[31]}}, w_word};
            default: w_ld_value = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = in_is_load ? WAIT : COMMIT;
            end
            WAIT: begin
                if (mem_rvalid || w_timeout) w_state_next = COMMIT;
            end
            COMMIT: begin
                if (w_accept) w_state_next = in_is_load ? WAIT : COMMIT;
                else          w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Holding registers: capture on accept, fill in load data or abandon while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_rd       <= '0;
            r_rd_wen   <= 1'b0;
            r_result   <= '0;
            r_is_load  <= 1'b0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_pc       <= in_pc;
            r_rd       <= in_rd;
            r_rd_wen   <= in_rd_wen;
            r_result   <= in_result;
            r_is_load  <= in_is_load;
            r_size     <= in_ld_size;
            r_unsigned <= in_ld_unsigned;
            r_cnt      <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 16'd1;
            if (mem_rvalid) begin
                r_result <= w_ld_value;
            end else if (w_timeout) begin
                r_err    <= 1'b1;
                r_rd_wen <= 1'b0;
            end
        end
    end

    // Commit, bypass and hazard outputs, all forced low while in reset.
    always_comb begin
        update        = 1'b0;
        commit_pc     = '0;
        wr_en         = 1'b0;
        index_rd      = '0;
        data_rd       = '0;
        fwd_valid     = 1'b0;
        fwd_rd        = '0;
        fwd_data      = '0;
        ld_pending    = 1'b0;
        ld_pending_rd = '0;
        err_timeout   = r_err && !rst;
        if (w_commit) begin
            update    = 1'b1;
            commit_pc = r_pc;
            wr_en     = r_rd_wen && (r_rd != 5'd0);
            index_rd  = r_rd;
            data_rd   = r_result;
            fwd_valid = r_rd_wen && (r_rd != 5'd0);
            fwd_rd    = r_rd;
            fwd_data  = r_result;
        end
        if (!rst && r_state == WAIT) begin
            ld_pending    = 1'b1;
            ld_pending_rd = r_rd;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a table of single-instruction vectors
// (non-loads and every load size/extension) plus hand-written sequences for
// back-to-back issue, timeout, stray mem_rvalid and reset mid-operation.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic        in_rd_wen;
    logic [4:0]  in_rd;
    logic [63:0] in_result;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wr_en;
    logic [4:0]  index_rd;
    logic [63:0] data_rd;
    logic        update;
    logic [63:0] commit_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        ld_pending;
    logic [4:0]  ld_pending_rd;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rd_wen     (in_rd_wen),
        .in_rd         (in_rd),
        .in_result     (in_result),
        .in_is_load    (in_is_load),
        .in_ld_size    (in_ld_size),
        .in_ld_unsigned(in_ld_unsigned),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wr_en         (wr_en),
        .index_rd      (index_rd),
        .data_rd       (data_rd),
        .update        (update),
        .commit_pc     (commit_pc),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .ld_pending    (ld_pending),
        .ld_pending_rd (ld_pending_rd),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [63:0] rdata;
        logic        exp_wen;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_insn(input logic ld, input logic [1:0] sz, input logic uns,
                              input logic [4:0] rd, input logic [63:0] res,
                              input logic [63:0] pc);
        in_valid       = 1'b1;
        in_is_load     = ld;
        in_ld_size     = sz;
        in_ld_unsigned = uns;
        in_rd          = rd;
        in_rd_wen      = 1'b1;
        in_result      = res;
        in_pc          = pc;
    endtask

    // One vector: accept, wait 4 cycles for loads, return data, check commit.
    task automatic run_vec(input int idx, input vec_t v);
        logic [63:0] pc;
        pc = 64'h8000_0000 + 64'(idx * 4);
        drive_insn(v.is_load, v.size, v.uns, v.rd, v.res, pc);
        @(negedge clk);
        chk($sformatf("v%0d in_ready_idle", idx), 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        if (v.is_load) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk($sformatf("v%0d ld_pending", idx), 64'(ld_pending), 64'd1);
                chk($sformatf("v%0d in_ready_wait", idx), 64'(in_ready), 64'd0);
                chk($sformatf("v%0d ld_pending_rd", idx), 64'(ld_pending_rd), 64'(v.rd));
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(negedge clk);
            chk($sformatf("v%0d update_on_rvalid", idx), 64'(update), 64'd0);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        chk($sformatf("v%0d update", idx), 64'(update), 64'd1);
        chk($sformatf("v%0d wr_en", idx), 64'(wr_en), 64'(v.exp_wen));
        chk($sformatf("v%0d fwd_valid", idx), 64'(fwd_valid), 64'(v.exp_wen));
        chk($sformatf("v%0d index_rd", idx), 64'(index_rd), 64'(v.rd));
        chk($sformatf("v%0d data_rd", idx), data_rd, v.exp_data);
        chk($sformatf("v%0d fwd_data", idx), fwd_data, v.exp_data);
        chk($sformatf("v%0d commit_pc", idx), commit_pc, pc);
        chk($sformatf("v%0d ld_pending_commit", idx), 64'(ld_pending), 64'd0);
        $display("[TB] vec %0d load=%0d size=%0d uns=%0d rd=%0d data_rd=0x%0h", idx,
                 v.is_load, v.size, v.uns, v.rd, data_rd);
        tick();
        @(negedge clk);
        chk($sformatf("v%0d update_after", idx), 64'(update), 64'd0);
        tick();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 5'd5,  64'h1234,                64'h0,                   1'b1, 64'h1234};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 5'd0,  64'h55,                  64'h0,                   1'b0, 64'h55};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 5'd7,  64'h1003,                64'h0000_0000_8000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[3]  = '{1'b1, 2'd0, 1'b1, 5'd7,  64'h1003,                64'h0000_0000_8000_0000, 1'b1, 64'h80};
        vecs[4]  = '{1'b1, 2'd2, 1'b0, 5'd8,  64'h2004,                64'h8765_4321_0000_0000, 1'b1, 64'hFFFF_FFFF_8765_4321};
        vecs[5]  = '{1'b1, 2'd2, 1'b1, 5'd8,  64'h2004,                64'h8765_4321_0000_0000, 1'b1, 64'h8765_4321};
        vecs[6]  = '{1'b1, 2'd3, 1'b0, 5'd9,  64'h2000,                64'h8765_4321_0000_0000, 1'b1, 64'h8765_4321_0000_0000};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 5'd10, 64'h3006,                64'h8001_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        vecs[8]  = '{1'b1, 2'd1, 1'b1, 5'd10, 64'h3007,                64'h8001_0000_0000_0000, 1'b1, 64'h8001};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 5'd11, 64'h4000,                64'h0000_0000_0000_007F, 1'b1, 64'h7F};
        vecs[10] = '{1'b1, 2'd3, 1'b1, 5'd12, 64'h4008,                64'hFEDC_BA98_7654_3210, 1'b1, 64'hFEDC_BA98_7654_3210};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 5'd0,  64'h5000,                64'h0000_0001_FFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};

        rst = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_rd_wen = 1'b0; in_rd = '0; in_result = '0;
        in_is_load = 1'b0; in_ld_size = '0; in_ld_unsigned = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        in_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst update", 64'(update), 64'd0);
        chk("rst err", 64'(err_timeout), 64'd0);
        chk("rst ld_pending", 64'(ld_pending), 64'd0);
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst in_ready", 64'(in_ready), 64'd1);
        chk("post_rst update", 64'(update), 64'd0);
        tick();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Back-to-back non-loads commit on consecutive cycles.
        for (int i = 1; i <= 3; i++) begin
            drive_insn(1'b0, 2'd0, 1'b0, 5'(i), 64'(i * 16'h1111), 64'h100 + 64'(i));
            @(negedge clk);
            chk($sformatf("b2b%0d in_ready", i), 64'(in_ready), 64'd1);
            if (i > 1) begin
                chk($sformatf("b2b%0d prev_update", i), 64'(update), 64'd1);
                chk($sformatf("b2b%0d prev_idx", i), 64'(index_rd), 64'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b3 update", 64'(update), 64'd1);
        chk("b2b3 idx", 64'(index_rd), 64'd3);
        chk("b2b3 data", data_rd, 64'h3333);
        $display("[TB] back-to-back rd=1,2,3 done");
        tick();
        @(negedge clk);
        chk("b2b idle update", 64'(update), 64'd0);
        tick();

        // Load that never gets data: abandons after 8 wait cycles.
        drive_insn(1'b1, 2'd3, 1'b0, 5'd9, 64'h6000, 64'h200);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("to wait%0d err", i), 64'(err_timeout), 64'd0);
            chk($sformatf("to wait%0d pending", i), 64'(ld_pending), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("to err", 64'(err_timeout), 64'd1);
        chk("to update", 64'(update), 64'd1);
        chk("to wr_en", 64'(wr_en), 64'd0);
        chk("to fwd_valid", 64'(fwd_valid), 64'd0);
        $display("[TB] timeout load rd=9 err_timeout=%0d", err_timeout);
        tick();
        // Stray mem_rvalid while idle is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        @(negedge clk);
        chk("stray err_sticky", 64'(err_timeout), 64'd1);
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray update", 64'(update), 64'd0);
        chk("stray pending", 64'(ld_pending), 64'd0);
        chk("stray in_ready", 64'(in_ready), 64'd1);
        $display("[TB] stray mem_rvalid in IDLE");
        run_vec(0, vecs[0]);
        @(negedge clk);
        chk("err still sticky", 64'(err_timeout), 64'd1);

        // Reset while a load waits: entry dropped, later data ignored.
        drive_insn(1'b1, 2'd0, 1'b0, 5'd4, 64'h7000, 64'h300);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rw pending", 64'(ld_pending), 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rw rst in_ready", 64'(in_ready), 64'd0);
        chk("rw rst pending", 64'(ld_pending), 64'd0);
        chk("rw rst err", 64'(err_timeout), 64'd0);
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFF;
        @(negedge clk);
        chk("rw idle update", 64'(update), 64'd0);
        chk("rw idle pending", 64'(ld_pending), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw after update", 64'(update), 64'd0);
        chk("rw after in_ready", 64'(in_ready), 64'd1);
        chk("rw err cleared", 64'(err_timeout), 64'd0);
        $display("[TB] reset during WAIT");

        // Reset while committing: no update issued.
        drive_insn(1'b0, 2'd0, 1'b0, 5'd6, 64'h66, 64'h400);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rc update", 64'(update), 64'd0);
        chk("rc wr_en", 64'(wr_en), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rc after update", 64'(update), 64'd0);
        chk("rc after in_ready", 64'(in_ready), 64'd1);
        $display("[TB] reset during COMMIT");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
